acc_sink16: RTL and testbench
=============================

# acc_sink16

Datapath companion to the 16-slot accumulate controller. It consumes the controller's `acc_sel` (slot 1, add bias) and `acc_en` (slot 16, finish) strobes together with the multiplier's per-slot product. It accumulates one neuron's 16 weighted inputs plus bias, then requantises the result: arithmetic shift, optional ReLU, signed saturation. The finished activation is delivered downstream through a 2-entry valid/ready output buffer. It sits between the MAC multiplier and the next layer's input stage.

## Interface
- `PROD_W`, 16: signed product / bias width.
- `ACC_W`, 24: signed accumulator width.
- `OUT_W`, 8: signed output width.
- `SHIFT`, 4: arithmetic right shift applied before saturation (0..ACC_W-1).
- `RELU`, 1: 1 = clamp negative results to 0; 0 = pass signed.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `acc_sel`  in  1  controller slot-1 flag; when set, the accumulator reloads with bias.
- `acc_en`  in  1  controller slot-16 flag; when set, the accumulation finishes.
- `prod_vld`  in  1  one-cycle strobe, one per 3-cycle slot; the product is valid.
- `prod`  in  PROD_W  signed product.
- `bias`  in  PROD_W  signed bias; sampled only when `prod_vld & acc_sel`.
- `out_valid`  out  1  head of the output buffer holds a result.
- `out_data`  out  OUT_W  signed requantised activation.
- `out_ready`  in  1  downstream accepts when `out_valid & out_ready`.
- `ovf`  out  1  sticky; a finished result was dropped because the buffer was full.
- `busy`  out  1  accumulation in progress (between slot 1 and slot 16).

## Operation
- `acc_sel`/`acc_en` are level signals held for a whole slot. They are acted on only in cycles with `prod_vld=1`; all other cycles hold state.
- Accumulator update on `prod_vld`:
  - `acc_sel=1`: acc <= sext(bias) + sext(prod).
  - `acc_sel=0`: acc <= acc + sext(prod).
- Accumulator arithmetic is two's complement, wrapping at ACC_W. ACC_W=24 cannot overflow for 16 terms plus bias at PROD_W=16.
- On `prod_vld & acc_en`:
  - final = (acc_sel ? sext(bias) : acc) + sext(prod).
  - r = final >>> SHIFT.
  - If RELU and r<0, r=0.
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Push r into the buffer.
- `acc` is also loaded with final, so a debug read is consistent.
- `busy`: set by `prod_vld & acc_sel & !acc_en`; cleared by `prod_vld & acc_en`.
- Buffer: 2-entry FIFO, first in first out.
  - Pop on `out_valid & out_ready`.
  - Push when full with no pop in the same cycle: the result is dropped and `ovf` is set.
  - Push when full with a pop in the same cycle: accepted.
  - Push when empty: accepted.
- `ovf` clears only on reset.
- A strobe with both `acc_sel` and `acc_en` set is legal. It yields bias + prod as a one-term result.

## Timing
- Reset (async assert, sync release) values: acc=0, buffer empty, `out_valid`=0, `out_data`=0, `ovf`=0, `busy`=0.
- Accumulator latency: `prod_vld` at cycle t updates acc visibly at t+1.
- Result latency: the slot-16 `prod_vld` at cycle t gives `out_valid`=1 with the result at t+1. Requantise is combinational into the buffer write; all outputs are registered.
- `out_data` is stable while `out_valid=1 & out_ready=0`.
- Throughput: one result per 48 cycles from the controller. The buffer absorbs up to 2 results of downstream stall (96 cycles).
- Reset mid-accumulation aborts the partial sum and discards buffered results. The next slot-1 strobe restarts cleanly.
- `prod_vld` without a prior slot-1 strobe after reset accumulates onto 0. The controller guarantees slot 1 first after reset.

## Structure
- Shared package `nn_pkg`:
  - width constants PROD_W/ACC_W/OUT_W;
  - saturation bounds;
  - `sat_q` function (shift + ReLU + saturate), reused by other layer sinks.
- Sub-module `res_fifo2`: 2-entry register FIFO with push/pop/full/empty, parameterised on OUT_W.
- Top holds the accumulator, the busy flag, the ovf flag and the requant path.

## Test plan
- SHIFT=2, RELU=1: bias=5, products 1..16 in slots 1..16 -> final=141, `out_data`=35, `out_valid` one cycle after the slot-16 strobe.
- Bias=0, all products=-100 -> final=-1600 -> ReLU -> `out_data`=0. Repeat with RELU=0 -> -100 after >>>4, saturates to -100 (within range); products all -1000 -> `out_data`=-128.
- All products=+2000, SHIFT=4 -> 32000>>>4=2000 -> `out_data`=127.
- `out_ready`=0 across three full 16-slot windows:
  - two results held in order;
  - third dropped, `ovf`=1;
  - then `out_ready`=1 drains exactly two results, `ovf` stays 1.
- Buffer full and push and pop in the same cycle -> no drop, `ovf` stays 0, order preserved.
- Assert `rst_n`=0 at slot 9 -> `busy`=0, `out_valid`=0; the next full window with bias=1, products all 1, SHIFT=0 -> `out_data`=17.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for neural-layer sinks: default widths, output saturation
// bounds, FIFO fill encoding and the requantiser (shift, optional ReLU, saturate).
package nn_pkg;

   localparam int PROD_W  = 16;
   localparam int ACC_W   = 24;
   localparam int OUT_W   = 8;
   localparam int SAT_W   = 32;
   localparam int OUT_MAX = (1 << (OUT_W - 1)) - 1;
   localparam int OUT_MIN = -(1 << (OUT_W - 1));

   typedef enum logic [1:0] {
      FILL_EMPTY = 2'd0,
      FILL_ONE   = 2'd1,
      FILL_TWO   = 2'd2
   } fill_e;

   function automatic logic signed [SAT_W-1:0] sat_q(
      input logic signed [SAT_W-1:0] v,
      input int unsigned             shift,
      input logic                    relu,
      input int unsigned             out_w
   );
      logic signed [SAT_W-1:0] r;
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
      lo = -hi - 32'sd1;
      r  = v >>> shift;
      if (relu && (r < 0)) r = '0;
      if (r > hi)      r = hi;
      else if (r < lo) r = lo;
      return r;
   endfunction

endpackage

// File: rtl/res_fifo2.sv
// Two-entry register FIFO for finished results; the head register drives the
// output directly so downstream sees a registered value.
module res_fifo2
   import nn_pkg::*;
#(
   parameter int OUT_W = nn_pkg::OUT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [OUT_W-1:0] i_din,
   output logic [OUT_W-1:0] o_dout,
   output logic             o_full,
   output logic             o_empty
);

   fill_e            r_fill;
   logic [OUT_W-1:0] r_head;
   logic [OUT_W-1:0] r_tail;
   logic             w_pop;
   logic             w_push;

   assign w_pop  = i_pop && (r_fill != FILL_EMPTY);
   // A push into a full buffer is still taken when the head leaves the same cycle.
   assign w_push = i_push && ((r_fill != FILL_TWO) || w_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fill <= FILL_EMPTY;
         r_head <= '0;
         r_tail <= '0;
      end else if (w_push && w_pop) begin
         if (r_fill == FILL_TWO) begin
            r_head <= r_tail;
            r_tail <= i_din;
         end else begin
            r_head <= i_din;
         end
      end else if (w_pop) begin
         if (r_fill == FILL_TWO) begin
            r_head <= r_tail;
            r_fill <= FILL_ONE;
         end else begin
            r_fill <= FILL_EMPTY;
         end
      end else if (w_push) begin
         if (r_fill == FILL_EMPTY) begin
            r_head <= i_din;
            r_fill <= FILL_ONE;
         end else begin
            r_tail <= i_din;
            r_fill <= FILL_TWO;
         end
      end
   end

   assign o_dout  = r_head;
   assign o_full  = (r_fill == FILL_TWO);
   assign o_empty = (r_fill == FILL_EMPTY);

endmodule

// File: rtl/acc_sink16.sv
// Accumulates one neuron's 16 weighted products plus bias, requantises the sum
// and hands the activation downstream through a 2-entry valid/ready buffer.
module acc_sink16
   import nn_pkg::*;
#(
   parameter int          PROD_W = nn_pkg::PROD_W,
   parameter int          ACC_W  = nn_pkg::ACC_W,
   parameter int          OUT_W  = nn_pkg::OUT_W,
   parameter int unsigned SHIFT  = 4,
   parameter bit          RELU   = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              acc_sel,
   input  logic              acc_en,
   input  logic              prod_vld,
   input  logic [PROD_W-1:0] prod,
   input  logic [PROD_W-1:0] bias,
   output logic              out_valid,
   output logic [OUT_W-1:0]  out_data,
   input  logic              out_ready,
   output logic              ovf,
   output logic              busy
);

   logic [ACC_W-1:0]        r_acc;
   logic                    r_busy;
   logic                    r_ovf;
   logic [ACC_W-1:0]        w_prod_x;
   logic [ACC_W-1:0]        w_bias_x;
   logic [ACC_W-1:0]        w_final;
   logic signed [SAT_W-1:0] w_final_x;
   logic [OUT_W-1:0]        w_q;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_full;
   logic                    w_empty;

   assign w_prod_x  = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
   assign w_bias_x  = {{(ACC_W - PROD_W){bias[PROD_W-1]}}, bias};
   // Slot 1 restarts from bias, so a combined slot-1/slot-16 strobe is a one-term result.
   assign w_final   = (acc_sel ? w_bias_x : r_acc) + w_prod_x;
   assign w_final_x = {{(SAT_W - ACC_W){w_final[ACC_W-1]}}, w_final};
   assign w_q       = OUT_W'(sat_q(w_final_x, SHIFT, RELU, OUT_W));

   assign w_push    = prod_vld && acc_en;
   assign w_pop     = !w_empty && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc  <= '0;
         r_busy <= 1'b0;
         r_ovf  <= 1'b0;
      end else begin
         if (prod_vld) r_acc <= w_final;
         if (prod_vld && acc_en)       r_busy <= 1'b0;
         else if (prod_vld && acc_sel) r_busy <= 1'b1;
         if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
      end
   end

   res_fifo2 #(
      .OUT_W(OUT_W)
   ) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_push (w_push),
      .i_pop  (w_pop),
      .i_din  (w_q),
      .o_dout (out_data),
      .o_full (w_full),
      .o_empty(w_empty)
   );

   assign out_valid = !w_empty;
   assign ovf       = r_ovf;
   assign busy      = r_busy;

endmodule

// File: tb/tb_acc_sink16.sv
// Bench for acc_sink16: three requantiser configurations share one stimulus stream
// and are compared every cycle against a queue-based model of sums and the buffer.
module tb_acc_sink16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        acc_sel = 1'b0;
   logic        acc_en = 1'b0;
   logic        prod_vld = 1'b0;
   logic [15:0] prod = '0;
   logic [15:0] bias = '0;
   logic        out_ready = 1'b0;

   logic        ov   [3];
   logic [7:0]  od   [3];
   logic        ovfw [3];
   logic        bsy  [3];

   int n_chk = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   int m_sum;
   bit m_busy;
   bit m_ovf;
   int q0[$];
   int q1[$];
   int q2[$];

   always #5 clk = ~clk;

   acc_sink16 #(.PROD_W(16), .ACC_W(24), .OUT_W(8), .SHIFT(2), .RELU(1'b1)) u_a (
      .clk(clk), .rst_n(rst_n), .acc_sel(acc_sel), .acc_en(acc_en), .prod_vld(prod_vld),
      .prod(prod), .bias(bias), .out_valid(ov[0]), .out_data(od[0]), .out_ready(out_ready),
      .ovf(ovfw[0]), .busy(bsy[0]));
   acc_sink16 #(.PROD_W(16), .ACC_W(24), .OUT_W(8), .SHIFT(4), .RELU(1'b0)) u_b (
      .clk(clk), .rst_n(rst_n), .acc_sel(acc_sel), .acc_en(acc_en), .prod_vld(prod_vld),
      .prod(prod), .bias(bias), .out_valid(ov[1]), .out_data(od[1]), .out_ready(out_ready),
      .ovf(ovfw[1]), .busy(bsy[1]));
   acc_sink16 #(.PROD_W(16), .ACC_W(24), .OUT_W(8), .SHIFT(0), .RELU(1'b0)) u_c (
      .clk(clk), .rst_n(rst_n), .acc_sel(acc_sel), .acc_en(acc_en), .prod_vld(prod_vld),
      .prod(prod), .bias(bias), .out_valid(ov[2]), .out_data(od[2]), .out_ready(out_ready),
      .ovf(ovfw[2]), .busy(bsy[2]));

   function automatic int quant(int s, int sh, bit relu);
      int r;
      r = s >>> sh;
      if (relu && r < 0) r = 0;
      if (r > 127) r = 127;
      if (r < -128) r = -128;
      return r;
   endfunction

   task automatic check(string nm, int act, int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         for (int k = 0; k < 3; k++) begin
            check($sformatf("valid%0d", k), int'(ov[k]), int'(q0.size() > 0));
            check($sformatf("ovf%0d", k), int'(ovfw[k]), int'(m_ovf));
            check($sformatf("busy%0d", k), int'(bsy[k]), int'(m_busy));
         end
         if (q0.size() > 0) begin
            check("data0", int'($signed(od[0])), q0[0]);
            check("data1", int'($signed(od[1])), q1[0]);
            check("data2", int'($signed(od[2])), q2[0]);
         end
      end
   end

   // Drive one cycle at the negedge and advance the model to the post-edge state.
   task automatic step(bit vld, bit sel, bit en, logic [15:0] p, logic [15:0] b, bit rdy);
      bit pop;
      bit full_before;
      @(negedge clk);
      prod_vld = vld; acc_sel = sel; acc_en = en; prod = p; bias = b; out_ready = rdy;
      full_before = (q0.size() == 2);
      pop = rdy && (q0.size() > 0);
      if (pop) begin
         void'(q0.pop_front()); void'(q1.pop_front()); void'(q2.pop_front());
      end
      if (vld) begin
         m_sum = (sel ? int'($signed(b)) : m_sum) + int'($signed(p));
         if (en) begin
            if (full_before && !pop) m_ovf = 1'b1;
            else begin
               q0.push_back(quant(m_sum, 2, 1'b1));
               q1.push_back(quant(m_sum, 4, 1'b0));
               q2.push_back(quant(m_sum, 0, 1'b0));
            end
            m_busy = 1'b0;
         end else if (sel) m_busy = 1'b1;
      end
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; prod_vld = 1'b0; acc_sel = 1'b0; acc_en = 1'b0; out_ready = 1'b0;
      m_sum = 0; m_busy = 1'b0; m_ovf = 1'b0;
      q0.delete(); q1.delete(); q2.delete();
      #1;
      for (int k = 0; k < 3; k++) begin
         check("rst_valid", int'(ov[k]), 0);
         check("rst_data", int'(od[k]), 0);
         check("rst_ovf", int'(ovfw[k]), 0);
         check("rst_busy", int'(bsy[k]), 0);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic idle(int n, int rmode);
      for (int i = 0; i < n; i++)
         step(1'b0, 1'b0, 1'b0, 16'($urandom), 16'($urandom),
              rmode == 2 ? bit'($urandom_range(0, 1)) : bit'(rmode));
   endtask

   // rmode: 0 stall, 1 ready, 2 random, 3 ready only on the slot-16 strobe cycle.
   task automatic window(int bias_v, int pv[16], int rmode, int abort_at);
      bit rdy;
      for (int s = 0; s < 16; s++) begin
         if (s == abort_at) begin
            do_reset();
            return;
         end
         for (int c = 0; c < 3; c++) begin
            case (rmode)
               0:       rdy = 1'b0;
               1:       rdy = 1'b1;
               2:       rdy = bit'($urandom_range(0, 1));
               default: rdy = (s == 15 && c == 0);
            endcase
            step(c == 0, s == 0, s == 15,
                 c == 0 ? 16'(pv[s]) : 16'($urandom),
                 (s == 0 && c == 0) ? 16'(bias_v) : 16'($urandom), rdy);
         end
      end
   endtask

   task automatic const_window(int bias_v, int v, int rmode);
      int pv[16];
      for (int i = 0; i < 16; i++) pv[i] = v;
      window(bias_v, pv, rmode, 99);
   endtask

   task automatic expect3(string nm, int ea, int eb, int ec);
      check({nm, "_a"}, int'($signed(od[0])), ea);
      check({nm, "_b"}, int'($signed(od[1])), eb);
      check({nm, "_c"}, int'($signed(od[2])), ec);
   endtask

   initial begin
      int pv[16];
      do_reset();
      chk_en = 1'b1;

      for (int i = 0; i < 16; i++) pv[i] = i + 1;
      window(5, pv, 0, 99);
      settle();
      check("mdl_141", q2.size() > 0 ? q2[0] : -999, 127);
      expect3("ramp", 35, 8, 127);
      idle(3, 1);

      const_window(0, -100, 0);
      settle();
      expect3("neg100", 0, -100, -128);
      idle(3, 1);

      const_window(0, -1000, 0);
      settle();
      expect3("neg1000", 0, -128, -128);
      idle(3, 1);

      const_window(0, 2000, 0);
      settle();
      expect3("pos2000", 127, 127, 127);
      idle(3, 1);

      step(1'b1, 1'b1, 1'b1, 16'd100, 16'd20, 1'b0);
      settle();
      expect3("oneterm", 30, 7, 120);
      idle(3, 1);

      const_window(0, 1, 0);
      const_window(0, 2, 0);
      const_window(0, 3, 3);
      settle();
      check("pp_ovf", int'(ovfw[0]), 0);
      check("mdl_pp", q2.size() > 0 ? q2[0] : -999, 32);
      expect3("pp_head", 8, 2, 32);
      step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
      settle();
      expect3("pp_next", 12, 3, 48);
      idle(3, 1);

      const_window(0, 1, 0);
      const_window(0, 2, 0);
      const_window(0, 3, 0);
      settle();
      check("of_ovf", int'(ovfw[2]), 1);
      expect3("of_head", 4, 1, 16);
      step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
      settle();
      expect3("of_next", 8, 2, 32);
      idle(4, 1);
      settle();
      check("of_empty", int'(ov[2]), 0);
      check("of_sticky", int'(ovfw[1]), 1);

      const_window(0, 7, 0);
      for (int i = 0; i < 16; i++) pv[i] = 1;
      window(9, pv, 0, 8);
      window(1, pv, 0, 99);
      settle();
      expect3("after_rst", 4, 1, 17);
      idle(3, 1);

      for (int w = 0; w < 30; w++) begin
         bit big;
         big = bit'($urandom_range(0, 1));
         for (int i = 0; i < 16; i++)
            pv[i] = big ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 300)) - 150;
         if ($urandom_range(0, 7) == 0)
            step(1'b1, 1'b1, 1'b1, 16'(pv[0]), 16'(pv[1]), bit'($urandom_range(0, 1)));
         else
            window(big ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 200)) - 100,
                   pv, 2, 99);
         idle(int'($urandom_range(0, 5)), 2);
      end
      idle(8, 1);
      settle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
